// File: rtl/cond_unit.sv
// Condition/flag stage: evaluates condition codes against forwarded flags,
// gates write/branch requests and owns the architectural {N,Z,C,V} register.
module cond_unit #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] cond,
  input  logic [1:0] flag_write,
  input  logic [3:0] alu_flags,
  input  logic       reg_write_in,
  input  logic       mem_write_in,
  input  logic       pc_src_in,
  input  logic       flush,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       cond_ex,
  output logic       reg_write,
  output logic       mem_write,
  output logic       pc_src,
  output logic [3:0] flags
);

  logic [3:0] flags_q, flags_d;
  logic       out_valid_q, out_valid_d;
  logic       cond_ex_q, cond_ex_d;
  logic       reg_write_q, reg_write_d;
  logic       mem_write_q, mem_write_d;
  logic       pc_src_q, pc_src_d;
  logic [1:0] flag_write_q, flag_write_d;
  logic [3:0] pend_flags_q, pend_flags_d;

  logic [3:0] eff;
  logic       base;
  logic       cond_true;
  logic       accept;
  logic       rel;

  assign in_ready = !flush && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign rel      = out_valid_q && out_ready;

  // Held instruction's update is visible to the next one before it commits.
  always_comb begin
    eff = flags_q;
    if (out_valid_q && cond_ex_q) begin
      if (flag_write_q[1]) eff[3:2] = pend_flags_q[3:2];
      if (flag_write_q[0]) eff[1:0] = pend_flags_q[1:0];
    end
  end

  // Odd codes are the inverse of the preceding even code (NV = !AL).
  always_comb begin
    base = 1'b1;
    case (cond[3:1])
      3'd0: base = eff[2];
      3'd1: base = eff[1];
      3'd2: base = eff[3];
      3'd3: base = eff[0];
      3'd4: base = eff[1] && !eff[2];
      3'd5: base = (eff[3] == eff[0]);
      3'd6: base = !eff[2] && (eff[3] == eff[0]);
      default: base = 1'b1;
    endcase
    cond_true = base ^ cond[0];
  end

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    flags_d      = flags_q;
    out_valid_d  = out_valid_q;
    cond_ex_d    = cond_ex_q;
    reg_write_d  = reg_write_q;
    mem_write_d  = mem_write_q;
    pc_src_d     = pc_src_q;
    flag_write_d = flag_write_q;
    pend_flags_d = pend_flags_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else begin
      if (rel && cond_ex_q) flags_d = eff;
      if (accept) begin
        out_valid_d  = 1'b1;
        cond_ex_d    = cond_true;
        reg_write_d  = reg_write_in;
        mem_write_d  = mem_write_in;
        pc_src_d     = pc_src_in;
        flag_write_d = flag_write;
        pend_flags_d = alu_flags;
      end else if (rel) begin
        out_valid_d = 1'b0;
      end
    end
  end

  // NOTE: state updates use non-blocking assignments so all flops sample together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q      <= RESET_FLAGS;
      out_valid_q  <= 1'b0;
      cond_ex_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      pc_src_q     <= 1'b0;
      flag_write_q <= 2'b00;
      pend_flags_q <= 4'b0000;
    end else begin
      flags_q      <= flags_d;
      out_valid_q  <= out_valid_d;
      cond_ex_q    <= cond_ex_d;
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      pc_src_q     <= pc_src_d;
      flag_write_q <= flag_write_d;
      pend_flags_q <= pend_flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign cond_ex   = cond_ex_q;
  assign flags     = flags_q;
  assign reg_write = out_valid_q && cond_ex_q && reg_write_q;
  assign mem_write = out_valid_q && cond_ex_q && mem_write_q;
  assign pc_src    = out_valid_q && cond_ex_q && pc_src_q;

endmodule

// File: doc/cond_unit.md
Name: cond_unit

Overview:
- Condition/flag stage that consumes the ALU result flags {N,Z,C,V} = ALUFlags[3:0] and owns the architectural flag register.
- Evaluates the instruction's 4-bit condition code against the flags and gates the write and branch enables.
- Commits flag updates from flag-setting ops.
- One registered valid/ready stage between execute and writeback, with forwarding of the in-flight flag update and a flush input for branch squash.

Parameters:
- RESET_FLAGS, 4'b0000, architectural flag value {N,Z,C,V} after reset.

Ports:
- clk  input  1  clock, single domain
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  instruction presented
- in_ready  output  1  stage can accept
- cond  input  4  condition code
- flag_write  input  2  [1]: update N,Z; [0]: update C,V
- alu_flags  input  4  {N,Z,C,V} from ALU for this instruction
- reg_write_in  input  1  ungated register-write request
- mem_write_in  input  1  ungated memory-write request
- pc_src_in  input  1  ungated branch request
- flush  input  1  squash held instruction
- out_valid  output  1  registered instruction valid
- out_ready  input  1  downstream accepts
- cond_ex  output  1  registered condition result
- reg_write  output  1  out_valid & cond_ex & held reg_write_in
- mem_write  output  1  out_valid & cond_ex & held mem_write_in
- pc_src  output  1  out_valid & cond_ex & held pc_src_in
- flags  output  4  architectural flags {N,Z,C,V}

Behaviour:
Reset (rst_n low, async):
- flags=RESET_FLAGS.
- out_valid=0, cond_ex=0, reg_write=mem_write=pc_src=0.
- Pending update cleared.

Handshake:
- accept = in_valid & in_ready.
- in_ready = !flush & (!out_valid | out_ready).
- Output is released on out_valid & out_ready.
- Output fields are stable while out_valid & !out_ready.

Effective flags (eff):
- eff = flags with the held instruction's pending update merged in, when out_valid & held cond_ex.
- flag_write[1] replaces N,Z; flag_write[0] replaces C,V.
- Otherwise eff = flags.

Condition evaluation (combinational on cond vs eff, captured at accept; latency 1 cycle to out_valid):
- 0 EQ Z
- 1 NE !Z
- 2 CS C
- 3 CC !C
- 4 MI N
- 5 PL !N
- 6 VS V
- 7 VC !V
- 8 HI C&!Z
- 9 LS !C|Z
- A GE N==V
- B LT N!=V
- C GT !Z&(N==V)
- D LE Z|(N!=V)
- E AL 1
- F NV 0

Capture at accept:
- Register cond_ex, the three requests, flag_write and alu_flags as the pending update.
- out_valid<=1.

Flag commit:
- On output release without flush: if held cond_ex, apply the pending update to flags.
- A failed condition never changes flags.
- Partial writes touch only the selected pair.

Back-to-back:
- Release and accept in the same cycle: the new instruction evaluates with eff (forwarded).
- flags commits the old update on that edge.

Release without accept: out_valid<=0.

Flush:
- Highest priority; in_ready=0 that cycle.
- Next edge: out_valid<=0, pending update discarded, flags unchanged.
- Flush with out_valid=0 is a no-op.
- Flush with out_ready=1 in the same cycle: squash wins, no commit.

Reset mid-operation: held instruction dropped, pending update never committed.

Test Plan:
- Reset: hold rst_n=0, then release -> flags=0000, out_valid=0, all enables 0, in_ready=1.
- Single op: present cond=E, flag_write=11, alu_flags=0100, reg_write_in=1, out_ready=1 -> next cycle out_valid=1, cond_ex=1, reg_write=1; following edge flags=0100.
- Forwarding: A (cond=E, flag_write=11, flags 0100) held one cycle with out_ready=0, then out_ready=1 while B (cond=0 EQ, pc_src_in=1) presented -> B accepted that cycle, B cond_ex=1, pc_src=1 despite flags=0000 at evaluation.
- Failed condition: flags=0000, present cond=0 EQ, flag_write=11, alu_flags=1010, mem_write_in=1 -> cond_ex=0, mem_write=0, flags stay 0000 after release.
- Partial write: flags=1111, cond=E, flag_write=01, alu_flags=0000 -> flags=1100 after release; then cond=B LT -> cond_ex=1.
- Flush: A held (flag_write=11, alu_flags=0100), assert flush with out_ready=1 and in_valid=1 -> in_ready=0, out_valid=0 next cycle, flags unchanged 0000, input not consumed. Also check cond=F -> cond_ex=0, all enables 0.
